// File: rtl/multicycle_control_if.sv
// Control-unit bus for the multicycle datapath.
// slave faces the controller; master faces the datapath side.
interface multicycle_control_if #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
);
  logic [OPW-1:0]  opcode;
  logic            mem_ready;
  logic            PCWrite;
  logic            PCWriteCond;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            MemtoReg;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic            HLT;
  logic            illegal;
  logic [2:0]      state;
  logic [CNTW-1:0] instret;

  modport master (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  PCSource, HLT, illegal,
    input  state, instret
  );

  modport slave (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp,
    output PCSource, HLT, illegal,
    output state, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with
// halt state and retired-instruction counter.
module multicycle_control #(
  parameter int             OPW     = 6,
  parameter int             CNTW    = 32,
  parameter logic [OPW-1:0] HALT_OP = '1
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.slave bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  state_t          st, nxt;
  logic [OPW-1:0]  op_q;
  logic [CNTW-1:0] cnt;

  logic is_r, is_addi, is_lw, is_sw;
  logic is_beq, is_j, is_halt, legal;

  assign is_r    = op_q == OP_R;
  assign is_addi = op_q == OP_ADDI;
  assign is_lw   = op_q == OP_LW;
  assign is_sw   = op_q == OP_SW;
  assign is_beq  = op_q == OP_BEQ;
  assign is_j    = op_q == OP_J;
  assign is_halt = op_q == HALT_OP;
  assign legal   = is_r | is_addi | is_lw
                 | is_sw | is_beq | is_j;

  logic       pcw, pcwc, iord, mrd, mwr, irw;
  logic       m2r, rdst, rgw, srca, hlt, ill;
  logic [1:0] srcb, aluop, pcsrc;
  logic       inc;

  always_comb begin
    nxt   = st;
    pcw   = 1'b0;
    pcwc  = 1'b0;
    iord  = 1'b0;
    mrd   = 1'b0;
    mwr   = 1'b0;
    irw   = 1'b0;
    m2r   = 1'b0;
    rdst  = 1'b0;
    rgw   = 1'b0;
    srca  = 1'b0;
    hlt   = 1'b0;
    ill   = 1'b0;
    srcb  = 2'b00;
    aluop = 2'b00;
    pcsrc = 2'b00;
    case (st)
      FETCH: begin
        mrd  = 1'b1;
        srcb = 2'b01;
        if (bus.mem_ready) begin
          irw = 1'b1;
          pcw = 1'b1;
          nxt = DECODE;
        end
      end
      DECODE: begin
        srcb = 2'b11;
        unique case (1'b1)
          is_halt: nxt = HALT;
          legal:   nxt = EXEC;
          default: begin
            ill = 1'b1;
            nxt = FETCH;
          end
        endcase
      end
      EXEC: begin
        unique case (1'b1)
          is_r: begin
            srca  = 1'b1;
            aluop = 2'b10;
            nxt   = WB;
          end
          is_addi: begin
            srca = 1'b1;
            srcb = 2'b10;
            nxt  = WB;
          end
          is_lw, is_sw: begin
            srca = 1'b1;
            srcb = 2'b10;
            nxt  = MEM;
          end
          is_beq: begin
            srca  = 1'b1;
            aluop = 2'b01;
            pcwc  = 1'b1;
            pcsrc = 2'b01;
            nxt   = FETCH;
          end
          is_j: begin
            pcw   = 1'b1;
            pcsrc = 2'b10;
            nxt   = FETCH;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        iord = 1'b1;
        mrd  = is_lw;
        mwr  = ~is_lw;
        if (bus.mem_ready)
          nxt = is_lw ? WB : FETCH;
      end
      WB: begin
        rgw  = 1'b1;
        rdst = is_r;
        m2r  = is_lw;
        nxt  = FETCH;
      end
      HALT:    hlt = 1'b1;
      default: nxt = FETCH;
    endcase
  end

  // Only instructions that ran to completion count as retired.
  assign inc = (nxt == FETCH)
             & ((st == EXEC) | (st == MEM) | (st == WB));

  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else     st <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      cnt  <= '0;
    end else begin
      if (st == FETCH && bus.mem_ready)
        op_q <= bus.opcode;
      if (inc)
        cnt <= cnt + CNTW'(1);
    end
  end

  // Reset is synchronous, so strobes are masked until the edge lands.
  assign bus.PCWrite     = pcw  & ~rst;
  assign bus.PCWriteCond = pcwc & ~rst;
  assign bus.IorD        = iord & ~rst;
  assign bus.MemRead     = mrd  & ~rst;
  assign bus.MemWrite    = mwr  & ~rst;
  assign bus.IRWrite     = irw  & ~rst;
  assign bus.MemtoReg    = m2r  & ~rst;
  assign bus.RegDst      = rdst & ~rst;
  assign bus.RegWrite    = rgw  & ~rst;
  assign bus.ALUSrcA     = srca & ~rst;
  assign bus.ALUSrcB     = srcb  & {2{~rst}};
  assign bus.ALUOp       = aluop & {2{~rst}};
  assign bus.PCSource    = pcsrc & {2{~rst}};
  assign bus.HLT         = hlt & ~rst;
  assign bus.illegal     = ill & ~rst;
  assign bus.state       = st;
  assign bus.instret     = cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control:
// full-width instance plus a CNTW=4 wrap instance.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPW(6), .CNTW(32)) bus ();
  multicycle_control_if #(.OPW(6), .CNTW(4))  bus2 ();

  multicycle_control #(.OPW(6), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  multicycle_control #(.OPW(6), .CNTW(4)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] ILL = 6'b010101;
  localparam logic [5:0] HOP = 6'b111111;

  // PCW PCWC IorD MRd MWr IRW M2R RDst RgW SrcA SrcB Op PCSrc HLT ill
  localparam logic [17:0] ZERO  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] F_RDY = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] F_WT  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] DEC_I = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] EX_R  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] EX_I  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] EX_B  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [17:0] EX_J  = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
  localparam logic [17:0] M_LW  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] M_SW  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] WB_R  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [17:0] WB_I  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [17:0] WB_L  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [17:0] HLTW  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [17:0] w;
    logic [31:0] ir;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   ncmp = 0;
  int   nfail = 0;
  bit   done2 = 1'b0;

  logic [17:0] w1, w2;
  assign w1 = {bus.PCWrite, bus.PCWriteCond, bus.IorD,
               bus.MemRead, bus.MemWrite, bus.IRWrite,
               bus.MemtoReg, bus.RegDst, bus.RegWrite,
               bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
               bus.PCSource, bus.HLT, bus.illegal};
  assign w2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.IorD,
               bus2.MemRead, bus2.MemWrite, bus2.IRWrite,
               bus2.MemtoReg, bus2.RegDst, bus2.RegWrite,
               bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUOp,
               bus2.PCSource, bus2.HLT, bus2.illegal};

  task automatic chk(input exp_t e, input logic [2:0] s,
                     input logic [17:0] w,
                     input logic [31:0] ir);
    ncmp++;
    if (s !== e.st || w !== e.w || ir !== e.ir) begin
      nfail++;
      $display("FAIL %s: got st=%0d w=%b ir=%0d, want st=%0d w=%b ir=%0d",
               e.tag, s, w, ir, e.st, e.w, e.ir);
    end
  endtask

  always @(negedge clk)
    if (sb1.size() > 0)
      chk(sb1.pop_front(), bus.state, w1, bus.instret);

  always @(negedge clk)
    if (sb2.size() > 0)
      chk(sb2.pop_front(), bus2.state, w2,
          32'(bus2.instret));

  task automatic cyc(input logic r, input logic [5:0] op,
                     input logic rdy, input logic [2:0] es,
                     input logic [17:0] ew, input int ei,
                     input string tag);
    rst = r;
    bus.opcode = op;
    bus.mem_ready = rdy;
    sb1.push_back('{tag, es, ew, 32'(ei)});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input logic r, input logic [5:0] op,
                      input logic rdy, input logic [2:0] es,
                      input logic [17:0] ew, input int ei,
                      input string tag);
    rst2 = r;
    bus2.opcode = op;
    bus2.mem_ready = rdy;
    sb2.push_back('{tag, es, ew, 32'(ei)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst2 = 1'b1;
    bus2.opcode = R;
    bus2.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc2(1, R, 1, 0, ZERO, 0, "s_rst");
    for (int i = 0; i < 17; i++) begin
      cyc2(0, R, 1, 0, F_RDY, i % 16, "s_f");
      cyc2(0, R, 1, 1, DEC,   i % 16, "s_d");
      cyc2(0, R, 1, 2, EX_R,  i % 16, "s_x");
      cyc2(0, R, 1, 4, WB_R,  i % 16, "s_wb");
    end
    cyc2(0, R, 0, 0, F_WT,  1, "s_wrap");
    cyc2(0, R, 1, 0, F_RDY, 1, "s_f2");
    cyc2(0, R, 1, 1, DEC,   1, "s_d2");
    cyc2(1, R, 1, 2, ZERO,  1, "s_rst_ex");
    cyc2(0, R, 0, 0, F_WT,  0, "s_after");
    cyc2(0, R, 0, 0, F_WT,  0, "s_after2");
    done2 = 1'b1;
  end

  initial begin
    rst = 1'b1;
    bus.opcode = R;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, LW, 1, 0, ZERO, 0, "rst");
    // lw, mem_ready high
    cyc(0, LW, 1, 0, F_RDY, 0, "lw_f");
    cyc(0, LW, 1, 1, DEC,   0, "lw_d");
    cyc(0, LW, 1, 2, EX_I,  0, "lw_x");
    cyc(0, LW, 1, 3, M_LW,  0, "lw_m");
    cyc(0, LW, 1, 4, WB_L,  0, "lw_wb");
    // sw with fetch wait and MEM stalls
    cyc(0, SW, 0, 0, F_WT,  1, "sw_fw");
    cyc(0, SW, 1, 0, F_RDY, 1, "sw_f");
    cyc(0, SW, 0, 1, DEC,   1, "sw_d");
    cyc(0, SW, 0, 2, EX_I,  1, "sw_x");
    cyc(0, SW, 0, 3, M_SW,  1, "sw_m0");
    cyc(0, SW, 0, 3, M_SW,  1, "sw_m1");
    cyc(0, SW, 0, 3, M_SW,  1, "sw_m2");
    cyc(0, SW, 1, 3, M_SW,  1, "sw_m3");
    cyc(0, BEQ, 1, 0, F_RDY, 2, "beq_f");
    cyc(0, BEQ, 1, 1, DEC,   2, "beq_d");
    cyc(0, BEQ, 1, 2, EX_B,  2, "beq_x");
    cyc(0, J, 1, 0, F_RDY, 3, "j_f");
    cyc(0, J, 1, 1, DEC,   3, "j_d");
    cyc(0, J, 1, 2, EX_J,  3, "j_x");
    cyc(0, R, 1, 0, F_RDY, 4, "r_f");
    cyc(0, R, 1, 1, DEC,   4, "r_d");
    cyc(0, R, 1, 2, EX_R,  4, "r_x");
    cyc(0, R, 1, 4, WB_R,  4, "r_wb");
    cyc(0, ADI, 1, 0, F_RDY, 5, "ai_f");
    cyc(0, ADI, 1, 1, DEC,   5, "ai_d");
    cyc(0, ADI, 1, 2, EX_I,  5, "ai_x");
    cyc(0, ADI, 1, 4, WB_I,  5, "ai_wb");
    cyc(0, ILL, 1, 0, F_RDY, 6, "ill_f");
    cyc(0, ILL, 1, 1, DEC_I, 6, "ill_d");
    cyc(0, HOP, 1, 0, F_RDY, 6, "h_f");
    cyc(0, HOP, 1, 1, DEC,   6, "h_d");
    for (int i = 0; i < 12; i++) begin
      logic [5:0] op;
      op = 6'(i * 7);
      cyc(0, op, i[0], 5, HLTW, 6, "halt");
    end
    cyc(1, R, 1, 5, ZERO, 6, "halt_rst");
    cyc(0, R, 0, 0, F_WT, 0, "post_rst");
    for (int k = 0; k < 2000 && !done2; k++)
      @(posedge clk);
    if (!done2) begin
      ncmp++;
      nfail++;
      $display("FAIL wrap_seq: got unfinished, want finished");
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb1.size() != 0 || sb2.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL drain: got %0d/%0d left, want 0/0",
               sb1.size(), sb2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule
